// File: rtl/sram_addr_slot_table_pkg.sv
// sram_addr_slot_table_pkg: shared constants, FSM encoding and slot index coding helpers.
// Slot index coding, common with the address comparator: 1..SLOTS names slot k+1, 0 means none.
package sram_addr_slot_table_pkg;

    localparam int SLOTS = 14;
    localparam int ADDR_W = 19;
    localparam logic [3:0] SLOT_NONE = 4'd0;

    typedef enum logic {IDLE, FLUSH} state_t;

    // Index 1..SLOTS to one-hot. 0 and out-of-range codes give an all-zero vector.
    function automatic logic [SLOTS-1:0] idx2oh(input logic [3:0] idx);
        logic [SLOTS-1:0] oh;
        for (int k = 0; k < SLOTS; k++) oh[k] = (idx == 4'(k + 1));
        return oh;
    endfunction

    // Lowest set bit to index 1..SLOTS, SLOT_NONE when no bit is set.
    function automatic logic [3:0] oh2idx(input logic [SLOTS-1:0] oh);
        logic [3:0] idx;
        idx = SLOT_NONE;
        for (int k = SLOTS - 1; k >= 0; k--) if (oh[k]) idx = 4'(k + 1);
        return idx;
    endfunction

endpackage

// File: rtl/sram_slot_prio_enc.sv
// sram_slot_prio_enc: finds the lowest clear bit of a slot vector.
// Ports: vec (in, SLOTS) vector to search; idx (out, 4) lowest clear bit as 1..SLOTS, 0 if none.
module sram_slot_prio_enc
    import sram_addr_slot_table_pkg::*;
(
    input  logic [SLOTS-1:0] vec,
    output logic [3:0]       idx
);

    assign idx = oh2idx(~vec);

endmodule

// File: rtl/sram_addr_slot_table.sv
// sram_addr_slot_table: outstanding SRAM address slot table with alloc, free, flush and optional aging.
// Ports: clk, reset (async active-low); alloc_valid/alloc_addr/alloc_ready request and
// alloc_done/alloc_index grant report; free_valid/free_index release; flush/flush_done clear-all;
// comp_addr_valid/data_comp_result comparator hit feedback; ena and addr_count_data_0..13 slot
// state to the comparator; full/free_count occupancy; age_evict_valid/age_evict_index eviction report.
// Build option: define SRAM_SLOT_AGE_EN to add per-slot idle counters and eviction.
module sram_addr_slot_table
    import sram_addr_slot_table_pkg::*;
#(
    parameter int               ADDR_W    = 19,
    parameter int               SLOTS     = 14,
    parameter int               AGE_W     = 16,
    parameter logic [AGE_W-1:0] AGE_LIMIT = 16'd50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_addr,
    output logic              alloc_ready,
    output logic              alloc_done,
    output logic [3:0]        alloc_index,
    input  logic              free_valid,
    input  logic [3:0]        free_index,
    input  logic              flush,
    output logic              flush_done,
    input  logic              comp_addr_valid,
    input  logic [3:0]        data_comp_result,
    output logic [SLOTS-1:0]  ena,
    output logic [ADDR_W-1:0] addr_count_data_0,
    output logic [ADDR_W-1:0] addr_count_data_1,
    output logic [ADDR_W-1:0] addr_count_data_2,
    output logic [ADDR_W-1:0] addr_count_data_3,
    output logic [ADDR_W-1:0] addr_count_data_4,
    output logic [ADDR_W-1:0] addr_count_data_5,
    output logic [ADDR_W-1:0] addr_count_data_6,
    output logic [ADDR_W-1:0] addr_count_data_7,
    output logic [ADDR_W-1:0] addr_count_data_8,
    output logic [ADDR_W-1:0] addr_count_data_9,
    output logic [ADDR_W-1:0] addr_count_data_10,
    output logic [ADDR_W-1:0] addr_count_data_11,
    output logic [ADDR_W-1:0] addr_count_data_12,
    output logic [ADDR_W-1:0] addr_count_data_13,
    output logic              full,
    output logic [3:0]        free_count,
    output logic              age_evict_valid,
    output logic [3:0]        age_evict_index
);

    state_t            state, state_n;
    logic [3:0]        ptr, ptr_n;
    logic [ADDR_W-1:0] addr_q [SLOTS];
    logic [SLOTS-1:0]  set_oh, free_oh, walk_oh, evict_oh, ena_n;
    logic [3:0]        grant, grant_q;
    logic              accept, acc_q, flush_end;

    sram_slot_prio_enc u_grant (.vec(ena), .idx(grant));

    assign full        = &ena;
    assign alloc_ready = (state == IDLE) && !full;
    assign accept      = alloc_valid && alloc_ready;
    assign set_oh      = accept ? idx2oh(grant) : '0;
    assign free_oh     = free_valid ? idx2oh(free_index) : '0;
    // Clears win over the grant set; all clear sources merge since a clear is a clear.
    assign ena_n       = (ena | set_oh) & ~(walk_oh | free_oh | evict_oh);

    always_comb begin
        free_count = '0;
        for (int k = 0; k < SLOTS; k++) free_count = free_count + {3'b0, ~ena[k]};
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        walk_oh   = '0;
        flush_end = 1'b0;
        if (state == IDLE) begin
            state_n = flush ? FLUSH : IDLE;
            ptr_n   = '0;
        end else begin
            walk_oh   = idx2oh(ptr + 4'd1);
            flush_end = (ptr == 4'(SLOTS - 1));
            ptr_n     = flush_end ? '0 : ptr + 4'd1;
            state_n   = flush_end ? IDLE : FLUSH;
        end
    end

    // alloc_done trails the slot enable by one cycle, hence the acc_q/grant_q stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            ena         <= '0;
            acc_q       <= 1'b0;
            grant_q     <= SLOT_NONE;
            alloc_done  <= 1'b0;
            alloc_index <= SLOT_NONE;
            flush_done  <= 1'b0;
            for (int k = 0; k < SLOTS; k++) addr_q[k] <= '0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            ena         <= ena_n;
            acc_q       <= accept;
            grant_q     <= accept ? grant : SLOT_NONE;
            alloc_done  <= acc_q;
            alloc_index <= grant_q;
            flush_done  <= flush_end;
            for (int k = 0; k < SLOTS; k++) if (set_oh[k]) addr_q[k] <= alloc_addr;
        end
    end

`ifdef SRAM_SLOT_AGE_EN
    logic [AGE_W-1:0] age [SLOTS];
    logic [SLOTS-1:0] expired;
    logic [3:0]       evict_idx;

    always_comb begin
        expired = '0;
        for (int k = 0; k < SLOTS; k++) expired[k] = ena[k] && (age[k] == AGE_LIMIT);
    end

    // Lowest clear bit of ~expired is the lowest expired slot.
    sram_slot_prio_enc u_evict (.vec(~expired), .idx(evict_idx));
    assign evict_oh = idx2oh(evict_idx);

    // Counters saturate at AGE_LIMIT so a slot passed over for a lower one stays expired.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age_evict_valid <= 1'b0;
            age_evict_index <= SLOT_NONE;
            for (int k = 0; k < SLOTS; k++) age[k] <= '0;
        end else begin
            age_evict_valid <= |expired;
            age_evict_index <= evict_idx;
            for (int k = 0; k < SLOTS; k++)
                if (set_oh[k] || (comp_addr_valid && data_comp_result == 4'(k + 1))) age[k] <= '0;
                else if (ena[k] && age[k] != AGE_LIMIT) age[k] <= age[k] + 1'b1;
        end
    end
`else
    logic             unused_comp;
    logic [AGE_W-1:0] unused_age;
    assign unused_comp     = ^{comp_addr_valid, data_comp_result};
    assign unused_age      = AGE_LIMIT;
    assign evict_oh        = '0;
    assign age_evict_valid = 1'b0;
    assign age_evict_index = SLOT_NONE;
`endif

    assign addr_count_data_0  = addr_q[0];
    assign addr_count_data_1  = addr_q[1];
    assign addr_count_data_2  = addr_q[2];
    assign addr_count_data_3  = addr_q[3];
    assign addr_count_data_4  = addr_q[4];
    assign addr_count_data_5  = addr_q[5];
    assign addr_count_data_6  = addr_q[6];
    assign addr_count_data_7  = addr_q[7];
    assign addr_count_data_8  = addr_q[8];
    assign addr_count_data_9  = addr_q[9];
    assign addr_count_data_10 = addr_q[10];
    assign addr_count_data_11 = addr_q[11];
    assign addr_count_data_12 = addr_q[12];
    assign addr_count_data_13 = addr_q[13];

endmodule

// File: tb/tb_sram_addr_slot_table.sv
// tb_sram_addr_slot_table: directed self-checking bench for sram_addr_slot_table.
module tb_sram_addr_slot_table;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alloc_valid = 1'b0, free_valid = 1'b0, flush = 1'b0, comp_addr_valid = 1'b0;
    logic [18:0] alloc_addr = '0;
    logic [3:0]  free_index = '0, data_comp_result = '0;
    logic        alloc_ready, alloc_done, flush_done, full, age_evict_valid;
    logic [3:0]  alloc_index, free_count, age_evict_index;
    logic [13:0] ena;
    logic [18:0] ad [14];
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    sram_addr_slot_table #(.AGE_LIMIT(16'd8)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
        .alloc_done(alloc_done), .alloc_index(alloc_index),
        .free_valid(free_valid), .free_index(free_index),
        .flush(flush), .flush_done(flush_done),
        .comp_addr_valid(comp_addr_valid), .data_comp_result(data_comp_result),
        .ena(ena),
        .addr_count_data_0(ad[0]), .addr_count_data_1(ad[1]), .addr_count_data_2(ad[2]),
        .addr_count_data_3(ad[3]), .addr_count_data_4(ad[4]), .addr_count_data_5(ad[5]),
        .addr_count_data_6(ad[6]), .addr_count_data_7(ad[7]), .addr_count_data_8(ad[8]),
        .addr_count_data_9(ad[9]), .addr_count_data_10(ad[10]), .addr_count_data_11(ad[11]),
        .addr_count_data_12(ad[12]), .addr_count_data_13(ad[13]),
        .full(full), .free_count(free_count),
        .age_evict_valid(age_evict_valid), .age_evict_index(age_evict_index)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int fd_cnt;
        int waited;
        logic [13:0] exp_ena;
        // Reset state
        tick();
        chk("rst_ena", ena, 0);
        chk("rst_done", alloc_done, 0);
        chk("rst_idx", alloc_index, 0);
        chk("rst_fdone", flush_done, 0);
        chk("rst_fcnt", free_count, 14);
        chk("rst_full", full, 0);
        chk("rst_addr0", ad[0], 0);
        chk("rst_evict", age_evict_valid, 0);
        @(negedge clk) reset = 1'b1;
        tick();

        // Single allocation
        alloc_valid = 1'b1; alloc_addr = 19'h00010;
        chk("a1_ready", alloc_ready, 1);
        tick();
        alloc_valid = 1'b0;
        chk("a1_ena", ena, 14'h0001);
        chk("a1_addr0", ad[0], 19'h00010);
        chk("a1_fcnt", free_count, 13);
        chk("a1_done_early", alloc_done, 0);
        tick();
        chk("a1_done", alloc_done, 1);
        chk("a1_idx", alloc_index, 1);
        tick();
        chk("a1_done_pulse", alloc_done, 0);

        // Fill the remaining 13 slots back to back, then hold a 15th request
        alloc_valid = 1'b1;
        for (int k = 1; k < 14; k++) begin
            alloc_addr = 19'h00100 + 19'(k);
            tick();
        end
        chk("fill_ena", ena, 14'h3FFF);
        chk("fill_full", full, 1);
        chk("fill_ready", alloc_ready, 0);
        chk("fill_fcnt", free_count, 0);
        chk("fill_addr13", ad[13], 19'h0010D);
        tick();
        chk("fill_last_done", alloc_done, 1);
        chk("fill_last_idx", alloc_index, 14);
        tick();
        tick();
        chk("held_no_done", alloc_done, 0);
        chk("held_ena", ena, 14'h3FFF);

        // Free slot 5 while full with a pending alloc: no grant this cycle
        free_valid = 1'b1; free_index = 4'd5; alloc_addr = 19'h5AAAA;
        chk("fa_ready", alloc_ready, 0);
        tick();
        free_valid = 1'b0;
        chk("fa_ena", ena, 14'h3FEF);
        chk("fa_ready2", alloc_ready, 1);
        tick();
        alloc_valid = 1'b0;
        chk("fa_ena2", ena, 14'h3FFF);
        chk("fa_addr4", ad[4], 19'h5AAAA);
        chk("fa_addr5", ad[5], 19'h00105);
        tick();
        chk("fa_done", alloc_done, 1);
        chk("fa_idx", alloc_index, 5);

        // Ignored free indices
        free_valid = 1'b1; free_index = 4'd0;
        tick();
        free_index = 4'd15;
        tick();
        free_valid = 1'b0;
        chk("free_ign", ena, 14'h3FFF);

        // Flush walk with a second flush mid-walk and alloc_valid held
        fd_cnt = 0;
        flush = 1'b1; alloc_valid = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            chk($sformatf("fl_ready_%0d", k), alloc_ready, 0);
            flush = (k == 6);
            if (k == 14) alloc_valid = 1'b0;
            tick();
            exp_ena = 14'h3FFF << k;
            chk($sformatf("fl_ena_%0d", k), ena, exp_ena);
            fd_cnt += int'(flush_done);
        end
        flush = 1'b0;
        chk("fl_done_last", flush_done, 1);
        tick();
        fd_cnt += int'(flush_done);
        chk("fl_done_count", fd_cnt, 1);
        chk("fl_ready_after", alloc_ready, 1);
        chk("fl_addr_kept", ad[4], 19'h5AAAA);
        tick();
        chk("fl_no_restart", ena, 0);

`ifdef SRAM_SLOT_AGE_EN
        // Idle slot ages out after AGE_LIMIT=8 enabled cycles
        alloc_valid = 1'b1; alloc_addr = 19'h00ABC;
        tick();
        alloc_valid = 1'b0;
        waited = 0;
        while (!age_evict_valid && waited < 30) begin
            tick();
            waited++;
        end
        chk("age_wait", waited, 9);
        chk("age_idx", age_evict_index, 1);
        chk("age_ena", ena, 0);
        tick();
        chk("age_pulse", age_evict_valid, 0);
        // Periodic hits keep the slot alive
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        fd_cnt = 0;
        for (int k = 1; k <= 32; k++) begin
            comp_addr_valid = (k % 4 == 0); data_comp_result = 4'd1;
            tick();
            fd_cnt += int'(age_evict_valid);
        end
        comp_addr_valid = 1'b0;
        chk("hit_no_evict", fd_cnt, 0);
        chk("hit_ena", ena, 14'h0001);
        free_valid = 1'b1; free_index = 4'd1;
        tick();
        free_valid = 1'b0;
`else
        waited = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            waited += int'(age_evict_valid);
        end
        chk("no_age_evict", waited, 0);
`endif

        // Reset mid-flush
        alloc_valid = 1'b1; alloc_addr = 19'h00777;
        tick(); tick(); tick();
        alloc_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rf_ena", ena, 0);
        chk("rf_fdone", flush_done, 0);
        chk("rf_fcnt", free_count, 14);
        chk("rf_addr0", ad[0], 0);
        chk("rf_idle", alloc_ready, 1);
        @(negedge clk) reset = 1'b1;
        alloc_valid = 1'b1; alloc_addr = 19'h01234;
        tick();
        alloc_valid = 1'b0;
        chk("rf_alloc_ena", ena, 14'h0001);

        // Reset mid-allocation: accepted grant never reports
        reset = 1'b0;
        #1;
        chk("ra_ena", ena, 0);
        chk("ra_done", alloc_done, 0);
        chk("ra_idx", alloc_index, 0);
        @(negedge clk) reset = 1'b1;
        tick();
        chk("ra_done_after", alloc_done, 0);
        alloc_valid = 1'b1; alloc_addr = 19'h04321;
        tick();
        alloc_valid = 1'b0;
        tick();
        chk("ra_regrant_done", alloc_done, 1);
        chk("ra_regrant_idx", alloc_index, 1);
        chk("ra_regrant_addr", ad[0], 19'h04321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
